// File: rtl/top_if.sv
// Player-facing signal bundle for the reaction-game round arbiter.
// The master side drives the buttons and the clear. The slave side returns the round result.
interface top_if;
  logic clr;
  logic pbi;
  logic pbr;
  logic winrnd;
  logic right;
  logic tie;

  modport master (output clr, pbi, pbr, input winrnd, right, tie);
  modport slave  (input clr, pbi, pbr, output winrnd, right, tie);
endinterface

// File: rtl/top.sv
// Two-player round arbiter: each button is synchronized and debounced.
// The first qualified press wins the round, or a same-cycle double press ties it.
module top #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  top_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES);

  typedef enum logic [1:0] {ARMED, WIN_L, WIN_R, TIE} state_e;

  // Index 0 is the left button (pbi); index 1 is the right button (pbr).
  logic [1:0]    s1_q, s2_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    fired_q, fired_d;
  logic [1:0]    qual;
  state_e        state_q;
  logic          winrnd_q, right_q, tie_q;

  // fired_q blocks re-qualification until s2 drops. clr sets it so that a button held through a clear is ignored.
  // s1 is included in qual so that the full DB_CYCLES+2 sample window must stay high.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      cnt_d[b]   = cnt_q[b];
      fired_d[b] = fired_q[b];
      qual[b]    = 1'b0;
      if (bus.clr) begin
        cnt_d[b]   = '0;
        fired_d[b] = 1'b1;
      end else if (!s2_q[b]) begin
        cnt_d[b]   = '0;
        fired_d[b] = 1'b0;
      end else begin
        if (cnt_q[b] != CntMax) cnt_d[b] = cnt_q[b] + CW'(1);
        if (cnt_q[b] == CntMax) begin
          fired_d[b] = 1'b1;
          qual[b]    = !fired_q[b] && s1_q[b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '{default: '0};
      fired_q <= '0;
    end else begin
      s1_q    <= {bus.pbr, bus.pbi};
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state_q  <= ARMED;
      winrnd_q <= 1'b0;
      right_q  <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (qual == 2'b11) begin
            state_q <= TIE;
            tie_q   <= 1'b1;
          end else if (qual == 2'b01) begin
            state_q  <= WIN_L;
            winrnd_q <= 1'b1;
          end else if (qual == 2'b10) begin
            state_q  <= WIN_R;
            winrnd_q <= 1'b1;
            right_q  <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign bus.winrnd = winrnd_q;
  assign bus.right  = right_q;
  assign bus.tie    = tie_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for the round arbiter. A sample-history model predicts the result every cycle.
module tb_top;
  localparam int DB  = 3;
  localparam int WIN = DB + 2;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  top_if bus ();

  top #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int failures = 0;

  // Model: a press qualifies at edge n when exactly the WIN samples n-WIN..n-1 were high after a low sample.
  // The run must also start no earlier than the most recent clr edge. Samples taken at rst edges count as low.
  bit histL [HMAX];
  bit histR [HMAX];
  int edgeN = 0;
  int lastClr = -1000;
  bit modelValid = 1'b0;
  int mState = 0;
  bit ql, qr;

  function automatic bit sampleOf(input int btn, input int k);
    return (btn == 0) ? histL[k] : histR[k];
  endfunction

  function automatic bit qualifies(input int btn, input int n);
    int s;
    s = n - WIN;
    if (s < 1) return 1'b0;
    if (s < lastClr) return 1'b0;
    if (sampleOf(btn, s - 1)) return 1'b0;
    for (int k = s; k < n; k++)
      if (!sampleOf(btn, k)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (edgeN < HMAX) begin
      if (rst) begin
        modelValid = 1'b1;
        mState = 0;
        lastClr = -1000;
        histL[edgeN] = 1'b0;
        histR[edgeN] = 1'b0;
      end else begin
        if (bus.clr) lastClr = edgeN;
        ql = qualifies(0, edgeN);
        qr = qualifies(1, edgeN);
        histL[edgeN] = bus.pbi;
        histR[edgeN] = bus.pbr;
        if (bus.clr) mState = 0;
        else if (mState == 0) begin
          if (ql && qr) mState = 3;
          else if (ql) mState = 1;
          else if (qr) mState = 2;
        end
      end
      edgeN++;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      testsRun++;
      if (bus.winrnd !== (mState == 1 || mState == 2) ||
          bus.right  !== (mState == 2) ||
          bus.tie    !== (mState == 3)) begin
        failures++;
        $display("[TB] FAIL model cycle %0d: got winrnd/right/tie=%b%b%b, expected state %0d",
                 edgeN, bus.winrnd, bus.right, bus.tie, mState);
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit c, input bit l, input bit rt, input int n);
    rst = r;
    bus.clr = c;
    bus.pbi = l;
    bus.pbr = rt;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input bit w, input bit rg, input bit t);
    testsRun++;
    if ({bus.winrnd, bus.right, bus.tie} !== {w, rg, t}) begin
      failures++;
      $display("[TB] FAIL %s: got %b%b%b, expected %b%b%b",
               name, bus.winrnd, bus.right, bus.tie, w, rg, t);
    end
  endtask

  initial begin
    bus.clr = 1'b0;
    bus.pbi = 1'b0;
    bus.pbr = 1'b0;

    applyStimulus(1, 1, 0, 0, 1);  checkOutput("reset", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 10); checkOutput("idle", 0, 0, 0);

    applyStimulus(0, 0, 0, 1, 5);  checkOutput("pbr before E5", 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);  checkOutput("pbr win E5", 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1);  checkOutput("clr after right", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 4);

    applyStimulus(0, 0, 1, 0, 6);  checkOutput("pbi win E5", 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 1, 6);  checkOutput("late pbr ignored", 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 4);  checkOutput("cleared", 0, 0, 0);

    applyStimulus(0, 0, 1, 1, 6);  checkOutput("tie E5", 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);  checkOutput("clr after tie", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 4);

    applyStimulus(0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 6);  checkOutput("glitch 3", 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 6);  checkOutput("glitch 4", 0, 0, 0);

    applyStimulus(0, 0, 1, 0, 5);  checkOutput("pbi 5 before edge", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);  checkOutput("pbi 5 samples win", 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 4);

    applyStimulus(0, 0, 1, 0, 8);  checkOutput("pbi held win", 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 1);  checkOutput("clr while held", 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 10); checkOutput("held after clr", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 3);
    applyStimulus(0, 0, 1, 0, 6);  checkOutput("re-press win", 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 4);

    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 1, 5);  checkOutput("pbi first", 1, 0, 0);
    applyStimulus(1, 0, 1, 1, 1);  checkOutput("rst mid hold", 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 5);  checkOutput("post rst wait", 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1);  checkOutput("post rst tie", 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 3);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
